core_seq: RTL and testbench

CORE_SEQ -- requirements
Module: core_seq

---
 rtl/core_seq.sv | 102 ++++++++++
 tb/tb_core_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq.sv
// core_seq: multi-cycle instruction sequencer FSM (optional MEM watchdog via CORE_SEQ_WDT_EN)
module core_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        reg_write,
    input  logic        mem_write,
    input  logic        mem_to_reg,
    input  logic [1:0]  jump,
    input  logic        mem_ack,
    output logic        pc_clr,
    output logic        ir_load,
    output logic        pc_en,
    output logic        rf_we,
    output logic        dm_req,
    output logic        dm_we,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] cyc_cnt
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t state, nxt;
    logic   clr, accept, rfw_q, dmw_q, wdt_hit;

    // a start is only honoured while parked, and only once per pc_clr pulse
    assign accept = (state == IDLE || state == HALT) && start && !clr;

    // next-state decode; the parked states leave only after the pc_clr cycle
    always_comb begin
        nxt = state;
        case (state)
            IDLE, HALT: nxt = clr ? FETCH : state;
            FETCH:      nxt = DECODE;
            DECODE:     nxt = (jump == 2'b01) ? HALT : EXEC;
            EXEC:       nxt = (mem_write | mem_to_reg) ? MEM : WB;
            MEM:        nxt = mem_ack ? WB : (wdt_hit ? HALT : MEM);
            WB:         nxt = FETCH;
            default:    nxt = IDLE;
        endcase
    end

    // state register and the registered pc_clr pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            clr   <= 1'b0;
        end else begin
            state <= nxt;
            clr   <= accept;
        end
    end

    // latch decoder qualifiers in EXEC so MEM/WB strobes depend on registers only; store wins over load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rfw_q <= 1'b0;
            dmw_q <= 1'b0;
        end else if (state == EXEC) begin
            rfw_q <= reg_write & ~mem_write;
            dmw_q <= mem_write;
        end
    end

    // busy-cycle counter: cleared by an accepted start, saturating, frozen when not busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cyc_cnt <= 16'h0000;
        else
            cyc_cnt <= accept ? 16'h0000 : (busy && cyc_cnt != 16'hFFFF) ? cyc_cnt + 16'h0001 : cyc_cnt;
    end

`ifdef CORE_SEQ_WDT_EN
    logic [3:0] wdt;

    assign wdt_hit = (state == MEM) && !mem_ack && (wdt == 4'hF);

    // count consecutive MEM cycles; the 16th without mem_ack aborts into HALT with err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt <= 4'h0;
            err <= 1'b0;
        end else begin
            wdt <= (state == MEM) ? wdt + 4'h1 : 4'h0;
            err <= accept ? 1'b0 : (err | wdt_hit);
        end
    end
`else
    assign wdt_hit = 1'b0;
    assign err     = 1'b0;
`endif

    assign pc_clr  = clr;
    assign ir_load = (state == FETCH);
    assign pc_en   = (state == WB);
    assign rf_we   = (state == WB) & rfw_q;
    assign dm_req  = (state == MEM);
    assign dm_we   = (state == MEM) & dmw_q;
    assign busy    = (state == FETCH) || (state == DECODE) || (state == EXEC) || (state == MEM) || (state == WB);
    assign done    = (state == HALT) && !clr;
endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: randomized scoreboard bench for core_seq (watchdog checks follow CORE_SEQ_WDT_EN)
module tb_core_seq;
    logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0;
    logic        reg_write = 1'b0, mem_write = 1'b0, mem_to_reg = 1'b0, mem_ack = 1'b0;
    logic [1:0]  jump = 2'b00;
    logic        pc_clr, ir_load, pc_en, rf_we, dm_req, dm_we, busy, done, err;
    logic [15:0] cyc_cnt;

    typedef struct {bit halt; bit rf; bit dw; bit er; int mem; int lat; int cyc;} exp_t;
    exp_t q[$];

    int cmp = 0, errs = 0, run_cyc = 0;
    int lat = 0, mc = 0;
    bit dw = 0, done_q = 0, e_start = 0, e_busy = 0;

    core_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .reg_write(reg_write), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .jump(jump), .mem_ack(mem_ack), .pc_clr(pc_clr), .ir_load(ir_load),
        .pc_en(pc_en), .rf_we(rf_we), .dm_req(dm_req), .dm_we(dm_we), .busy(busy), .done(done),
        .err(err), .cyc_cnt(cyc_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout reached without finishing");
        $fatal(1);
    end

    task automatic chk(input string nm, input longint a, input longint e);
        cmp++;
        if (a != e) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
        end
    endtask

    // monitor: capture what the DUT sampled at the edge
    always @(posedge clk) begin
        e_start = start;
        e_busy  = busy;
    end

    // monitor: per-instruction measurement and scoreboard compare
    always @(negedge clk) begin
        exp_t me;
        if (rst_n) begin
            if (ir_load) begin
                lat = 1; mc = 0; dw = 0;
            end else if (busy)
                lat++;
            if (dm_req) begin
                mc++;
                dw = dw | dm_we;
            end
            chk("rf_we_outside_wb", rf_we & ~pc_en, 0);
            chk("dm_we_outside_mem", dm_we & ~dm_req, 0);
            chk("pc_clr_while_busy", pc_clr & busy, 0);
            if (e_start && e_busy)
                chk("start_ignored", pc_clr, 0);
            if (pc_en || (done && !done_q)) begin
                if (q.size() == 0)
                    chk("unexpected_retire", 0, 1);
                else begin
                    me = q.pop_front();
                    if (pc_en) begin
                        if (me.halt)
                            chk("pc_en_in_halt_instr", pc_en, 0);
                        else begin
                            chk("wb_rf_we", rf_we, me.rf);
                            chk("mem_cycles", mc, me.mem);
                            chk("mem_dm_we", dw, me.dw);
                            chk("latency", lat, me.lat);
                            chk("wb_cyc_cnt", cyc_cnt, me.cyc);
                        end
                    end else if (!me.halt)
                        chk("done_in_normal_instr", done, 0);
                    else begin
                        chk("halt_latency", lat, me.lat);
                        chk("halt_cyc_cnt", cyc_cnt, me.cyc);
                        chk("halt_err", err, me.er);
                        chk("halt_busy", busy, 0);
                    end
                end
            end
            done_q = done;
        end else
            done_q = 0;
    end

    task automatic wait_ir(output bit ok);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = ir_load;
        end
        if (!ok) chk("ir_load_timeout", 0, 1);
    endtask

    task automatic start_prog();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("pc_clr_pulse", pc_clr, 1);
        chk("done_cleared", done, 0);
        chk("err_cleared", err, 0);
        chk("cyc_cleared", cyc_cnt, 0);
        chk("busy_in_clr", busy, 0);
        run_cyc = 0;
    endtask

    task automatic run_instr(input bit rw, input bit mw, input bit mr, input bit hlt, input int n);
        bit ok;
        int j;
        exp_t e;
        wait_ir(ok);
        if (!ok) return;
        j = $urandom_range(0, 2);
        reg_write  = rw;
        mem_write  = mw;
        mem_to_reg = mr;
        jump       = hlt ? 2'b01 : (j == 0 ? 2'b00 : j == 1 ? 2'b10 : 2'b11);
        mem_ack    = 1'($urandom);
        e.halt = hlt;
        e.rf   = rw & ~mw;
        e.dw   = mw;
        e.er   = 0;
        e.mem  = (hlt || !(mw | mr)) ? 0 : n;
        e.lat  = hlt ? 2 : 4 + e.mem;
        e.cyc  = run_cyc + (hlt ? 2 : e.lat - 1);
        run_cyc += e.lat;
        q.push_back(e);
        @(negedge clk);
        mem_ack = 1'($urandom);
        if (hlt) begin
            mem_ack = 1'b0;
            return;
        end
        @(negedge clk);
        start   = ($urandom_range(0, 3) == 0);
        mem_ack = 1'($urandom);
        @(negedge clk);
        start   = 1'b0;
        mem_ack = 1'b0;
        if (mw | mr) begin
            for (int k = 1; k <= n; k++) begin
                if (k > 1) @(negedge clk);
                mem_ack = (k == n);
                if (k == 1) start = 1'($urandom);
            end
            @(negedge clk);
            mem_ack = 1'b0;
            start   = 1'b0;
        end
    endtask

    task automatic random_prog();
        int nins, kind;
        start_prog();
        nins = $urandom_range(2, 6);
        for (int i = 0; i < nins; i++) begin
            kind = $urandom_range(0, 3);
            run_instr(1'($urandom), kind >= 2, kind == 1 || kind == 3, 1'b0, $urandom_range(1, 5));
        end
        run_instr(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1);
        repeat ($urandom_range(1, 4)) @(negedge clk);
        chk("halt_done_held", done, 1);
        chk("halt_not_busy", busy, 0);
    endtask

    initial begin
        bit ok;
        int cnt;
        exp_t e;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {pc_clr, ir_load, pc_en, rf_we, dm_req, dm_we, busy, done, err}, 0);
        chk("reset_cyc_cnt", cyc_cnt, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_waits", {busy, ir_load, pc_clr}, 0);

        start_prog();
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1);
        run_instr(1'b1, 1'b0, 1'b1, 1'b0, 3);
        run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1);
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 2);
        run_instr(1'b1, 1'b0, 1'b0, 1'b1, 1);
        repeat (3) @(negedge clk);
        chk("halt_done_held", done, 1);
        chk("halt_not_busy", busy, 0);

        for (int p = 0; p < 8; p++) random_prog();

        start_prog();
        wait_ir(ok);
        reg_write = 1'b1; mem_write = 1'b0; mem_to_reg = 1'b1; jump = 2'b00; mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("in_mem_before_reset", dm_req, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {pc_clr, ir_load, pc_en, rf_we, dm_req, dm_we, busy, done, err}, 0);
        chk("async_reset_cyc_cnt", cyc_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_after_reset", {busy, ir_load, pc_en, rf_we, dm_req}, 0);
        end

        start_prog();
        wait_ir(ok);
        reg_write = 1'b1; mem_write = 1'b0; mem_to_reg = 1'b1; jump = 2'b00; mem_ack = 1'b0;
        cnt = 0;
`ifdef CORE_SEQ_WDT_EN
        e.halt = 1; e.rf = 0; e.dw = 0; e.er = 1; e.mem = 16; e.lat = 19; e.cyc = 19;
        q.push_back(e);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!dm_req) break;
            cnt++;
        end
        chk("wdt_mem_cycles", cnt, 16);
        chk("wdt_err", err, 1);
        chk("wdt_done", done, 1);
        chk("wdt_dm_req", dm_req, 0);
`else
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cnt += int'(dm_req);
        end
        chk("mem_wait_cycles", cnt, 100);
        chk("no_err", err, 0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
